// File: rtl/alu_issue_queue.sv
// Command FIFO in front of the 4-bit combinational ALU. It holds each ALU answer in a
// result register that is handed downstream over a valid/ready handshake.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int CW    = 2,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [CW-1:0] cmd_c,
  input  logic [1:0]    cmd_op,
  output logic [DW-1:0] alu_inA,
  output logic [DW-1:0] alu_inB,
  output logic [CW-1:0] alu_inC,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_ans,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [1:0]    res_op,
  output logic          res_zero,
  output logic [PW:0]   count
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [CW-1:0] c;
    logic [1:0]    op;
  } cmdEntry_t;

  localparam logic [PW:0] fullCount = (PW+1)'(DEPTH);

  cmdEntry_t       mem [DEPTH];
  cmdEntry_t       head;
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic            push;
  logic            issue;
  logic            notEmpty;

  assign notEmpty  = (count != '0);
  assign cmd_ready = (count != fullCount);
  assign push      = cmd_valid & cmd_ready;
  assign issue     = notEmpty & (~res_valid | res_ready);
  assign head      = mem[rdPtr];
  assign res_zero  = (res_data == '0);

  // The ALU sees all zeros when nothing is queued, so it never computes on a stale slot.
  always_comb begin
    alu_inA = '0;
    alu_inB = '0;
    alu_inC = '0;
    alu_op  = '0;
    if (notEmpty) begin
      alu_inA = head.a;
      alu_inB = head.b;
      alu_inC = head.c;
      alu_op  = head.op;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{a: cmd_a, b: cmd_b, c: cmd_c, op: cmd_op};
    end
  end

  // Full and empty come from the occupancy count. Pointer equality is never used for this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (issue) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_ans;
      res_op    <= head.op;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue. It uses a behavioural ALU and a queue-based
// reference model, with directed scenarios followed by a randomized phase.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_c;
  logic [1:0] cmd_op;
  logic [3:0] alu_inA;
  logic [3:0] alu_inB;
  logic [1:0] alu_inC;
  logic [1:0] alu_op;
  logic [3:0] alu_ans;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_op;
  logic       res_zero;
  logic [2:0] count;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    logic [1:0] op;
  } cmdT;

  cmdT        modelQ[$];
  logic       modelValid;
  logic [3:0] modelData;
  logic [1:0] modelOp;

  alu_issue_queue #(.DEPTH(4), .DW(4), .CW(2), .PW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_op(cmd_op),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_op(alu_op),
    .alu_ans(alu_ans),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_zero(res_zero),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] c, input logic [1:0] op);
    logic signed [3:0] sa;
    logic [3:0] r;
    sa = a;
    case (op)
      2'b00:   r = 4'(sa >>> c);
      2'b01:   r = a >> c;
      2'b10:   r = a - b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Behavioural stand-in for the external combinational ALU.
  always_comb alu_ans = aluRef(alu_inA, alu_inB, alu_inC, alu_op);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    modelValid = 1'b0;
    modelData  = '0;
    modelOp    = '0;
  endtask

  task automatic checkAll();
    cmdT h;
    h = '{a: 4'd0, b: 4'd0, c: 2'd0, op: 2'd0};
    if (modelQ.size() > 0) h = modelQ[0];
    checkOutput("count",     32'(count),     32'(modelQ.size()));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(modelQ.size() != 4));
    checkOutput("res_valid", 32'(res_valid), 32'(modelValid));
    checkOutput("res_data",  32'(res_data),  32'(modelData));
    checkOutput("res_op",    32'(res_op),    32'(modelOp));
    checkOutput("res_zero",  32'(res_zero),  32'(modelData == 4'd0));
    checkOutput("alu_inA",   32'(alu_inA),   32'(h.a));
    checkOutput("alu_inB",   32'(alu_inB),   32'(h.b));
    checkOutput("alu_inC",   32'(alu_inC),   32'(h.c));
    checkOutput("alu_op",    32'(alu_op),    32'(h.op));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then compare.
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] c, input logic [1:0] op, input logic rdy);
    bit doIssue;
    bit doPush;
    cmdT h;
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = c;
    cmd_op    = op;
    res_ready = rdy;
    @(posedge clk);
    doIssue = (modelQ.size() > 0) && (!modelValid || rdy);
    doPush  = v && (modelQ.size() < 4);
    if (doIssue) begin
      h = modelQ.pop_front();
      modelValid = 1'b1;
      modelData  = aluRef(h.a, h.b, h.c, h.op);
      modelOp    = h.op;
    end else if (modelValid && rdy) begin
      modelValid = 1'b0;
    end
    if (doPush) modelQ.push_back('{a: a, b: b, c: c, op: op});
    #1;
    checkAll();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_op = '0;
    res_ready = 1'b0;
    resetModel();
    #12;
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset res_zero", 32'(res_zero), 32'd1);
    rst_n = 1'b1;
    #1;
    checkAll();

    // Single sra command: 1000 >>> 2 = 1110.
    applyStimulus(1'b1, 4'd8, 4'd0, 2'd2, 2'b00, 1'b1);
    checkOutput("single alu_inA", 32'(alu_inA), 32'd8);
    applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 2'b00, 1'b1);
    checkOutput("single res_valid", 32'(res_valid), 32'd1);
    checkOutput("single res_data", 32'(res_data), 32'hE);
    checkOutput("single res_zero", 32'(res_zero), 32'd0);
    idle(1'b1, 2);

    // Back-to-back commands with res_ready held high.
    applyStimulus(1'b1, 4'd8, 4'd0, 2'd2, 2'b01, 1'b1);
    applyStimulus(1'b1, 4'd4, 4'd4, 2'd0, 2'b10, 1'b1);
    checkOutput("b2b srl", 32'(res_data), 32'd2);
    applyStimulus(1'b1, 4'd9, 4'd9, 2'd0, 2'b11, 1'b1);
    checkOutput("b2b sub", 32'(res_data), 32'd0);
    checkOutput("b2b sub zero", 32'(res_zero), 32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 2'b00, 1'b1);
    checkOutput("b2b add wrap", 32'(res_data), 32'd2);
    idle(1'b1, 2);

    // Backpressure: six offered commands, one captured and four queued.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 4'(k + 1), 4'd3, 2'(k), 2'(k), 1'b0);
    checkOutput("bp count full", 32'(count), 32'd4);
    checkOutput("bp cmd_ready", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 2'b00, 1'b1);
    checkOutput("bp ready back", 32'(cmd_ready), 32'd1);
    checkOutput("bp count 3", 32'(count), 32'd3);
    idle(1'b1, 6);

    // Fill to two entries, then push and pop together so both pointers wrap.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'(k), 4'd1, 2'd0, 2'b11, 1'b0);
    for (int k = 3; k < 13; k++) begin
      applyStimulus(1'b1, 4'(k), 4'd1, 2'd0, 2'b11, 1'b1);
      checkOutput("steady count", 32'(count), 32'd2);
    end
    idle(1'b1, 4);
    checkOutput("empty alu_inA", 32'(alu_inA), 32'd0);
    checkOutput("empty res_valid", 32'(res_valid), 32'd0);
    checkOutput("empty res_data hold", 32'(res_data), 32'd13);

    // Asynchronous reset mid-burst with three queued and one result pending.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'(k + 5), 4'd2, 2'd1, 2'b10, 1'b0);
    checkOutput("pre-reset count", 32'(count), 32'd3);
    checkOutput("pre-reset res_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async count", 32'(count), 32'd0);
    checkOutput("async res_valid", 32'(res_valid), 32'd0);
    checkOutput("async res_zero", 32'(res_zero), 32'd1);
    #3 rst_n = 1'b1;
    #1;
    checkAll();
    idle(1'b1, 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(1'b1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
